// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT reorder buffer.
package fft_pkg;

    localparam int FFT_N_DEFAULT = 1024;
    localparam int DATA_W        = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Reverses the low 'width' bits of val; bits above width come back as zero.
    function automatic int unsigned bitrev(input int unsigned val, input int width);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[i] = val[width-1-i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port sample RAM with a registered, resettable read port.
module fft_reorder_bank #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset so the outputs start at zero; contents are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural bin order out.
// Optional output frame counter enabled by defining FFT_REORDER_FRAMECNT_EN.
module fft_bitrev_reorder #(
    parameter int FFT_N  = fft_pkg::FFT_N_DEFAULT,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_err,
    output logic [15:0]       out_frame_cnt
);
    import fft_pkg::bitrev;

    localparam int AW = $clog2(FFT_N);
    localparam logic [AW-1:0] LAST = AW'(FFT_N - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]          state;
    logic [AW-1:0]       wr_cnt;
    logic [AW-1:0]       rd_cnt;
    logic [AW-1:0]       wr_idx;
    logic                bank_sel;
    logic                sof_err;
    logic                wr_en;
    logic                rd_en;
    logic [AW:0]         wr_addr;
    logic [AW:0]         rd_addr;
    logic [2*DATA_W-1:0] rd_word;

    // A sof always lands at index 0, whether it starts a frame or resyncs one.
    assign wr_idx  = in_sof ? '0 : wr_cnt;
    assign sof_err = in_valid && in_sof && (state != IDLE) && (wr_cnt != '0);
    assign wr_en   = in_valid && ((state != IDLE) || in_sof);
    assign rd_en   = in_valid && (state == STREAM) && !sof_err;
    assign wr_addr = {bank_sel, AW'(bitrev(32'(wr_idx), AW))};
    assign rd_addr = {~bank_sel, rd_cnt};

    fft_reorder_bank #(
        .ADDR_W(AW + 1),
        .WORD_W(2 * DATA_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data({in_re, in_im}),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_word)
    );

    assign out_re = rd_word[2*DATA_W-1:DATA_W];
    assign out_im = rd_word[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            bank_sel  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_sof   <= rd_en && (rd_cnt == '0);
            if (sof_err) begin
                out_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_sof) begin
                        wr_cnt <= AW'(1);
                        state  <= FILL;
                    end
                end
                FILL, STREAM: begin
                    if (in_valid) begin
                        if (sof_err) begin
                            // Drop the partial frame and refill from the new sof.
                            wr_cnt <= AW'(1);
                            rd_cnt <= '0;
                            state  <= FILL;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                            if (state == STREAM) begin
                                rd_cnt <= rd_cnt + AW'(1);
                            end
                            if (wr_cnt == LAST) begin
                                bank_sel <= ~bank_sel;
                                rd_cnt   <= '0;
                                state    <= STREAM;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FFT_REORDER_FRAMECNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_frame_cnt <= '0;
        end else if (out_valid && out_sof) begin
            out_frame_cnt <= out_frame_cnt + 16'd1;
        end
    end
`else
    assign out_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder at FFT_N=8; a frame-level model predicts every output cycle.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic        valid;
        logic        sof;
        logic [15:0] re;
        logic [15:0] im;
        logic        err;
        logic [15:0] fcnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_sof;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_err;
    logic [15:0] out_frame_cnt;

    int    checks;
    int    errors;
    logic  mon_en;
    exp_t  exp_q[$];

    int    m_state;
    int    m_cnt;
    cplx_t m_cur[N];
    cplx_t m_prev[N];
    exp_t  m_last;

    int    exp_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_reorder #(
        .FFT_N (N),
        .DATA_W(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_re        (in_re),
        .in_im        (in_im),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_re       (out_re),
        .out_im       (out_im),
        .out_err      (out_err),
        .out_frame_cnt(out_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 3; b++) begin
            if ((k & (1 << b)) != 0) r = r | (1 << (2 - b));
        end
        return r;
    endfunction

    // Drives one clock of stimulus and queues the output the design must show after that edge.
    task automatic drive_cycle(input logic v, input logic s, input logic [15:0] re, input logic [15:0] im);
        exp_t e;
        in_valid = v;
        in_sof   = s;
        in_re    = re;
        in_im    = im;
        e        = m_last;
        e.valid  = 1'b0;
        e.sof    = 1'b0;
`ifdef FFT_REORDER_FRAMECNT_EN
        e.fcnt   = m_last.fcnt + 16'(m_last.valid & m_last.sof);
`endif
        if (rst) begin
            e       = '0;
            m_state = 0;
            m_cnt   = 0;
        end else if (v) begin
            if (m_state == 0) begin
                if (s) begin
                    m_cur[0] = cplx_t'({re, im});
                    m_cnt    = 1;
                    m_state  = 1;
                end
            end else if (s && m_cnt != 0) begin
                e.err    = 1'b1;
                m_cur[0] = cplx_t'({re, im});
                m_cnt    = 1;
                m_state  = 1;
            end else begin
                if (m_state == 2) begin
                    e.valid = 1'b1;
                    e.sof   = (m_cnt == 0);
                    e.re    = m_prev[tb_bitrev(m_cnt)].re;
                    e.im    = m_prev[tb_bitrev(m_cnt)].im;
                end
                m_cur[m_cnt] = cplx_t'({re, im});
                m_cnt++;
                if (m_cnt == N) begin
                    m_prev  = m_cur;
                    m_cnt   = 0;
                    m_state = 2;
                end
            end
        end
        m_last = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            exp_t act;
            act = '{out_valid, out_sof, out_re, out_im, out_err, out_frame_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_underflow: got v=%0b with no expected entry at %0t", out_valid, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("[TB] FAIL scoreboard at %0t: got v=%0b sof=%0b re=%h im=%h err=%0b fcnt=%0d, expected v=%0b sof=%0b re=%h im=%h err=%0b fcnt=%0d",
                             $time, act.valid, act.sof, act.re, act.im, act.err, act.fcnt,
                             e.valid, e.sof, e.re, e.im, e.err, e.fcnt);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        drive_cycle(1'b1, 1'b1, 16'h1234, 16'h5678);
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_re !== 16'h0 || out_im !== 16'h0 ||
            out_err !== 1'b0 || out_frame_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got v=%0b sof=%0b re=%h im=%h err=%0b fcnt=%0d, expected all zero",
                     out_valid, out_sof, out_re, out_im, out_err, out_frame_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_two_frames();
        do_reset();
        for (int j = 0; j < N; j++) drive_cycle(1'b1, j == 0, 16'(j), 16'(100 + j));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_silent: got out_valid=%0b, expected 0", out_valid);
        end
        for (int j = 0; j < N; j++) begin
            drive_cycle(1'b1, j == 0, 16'(8 + j), 16'(200 + j));
            checks++;
            if (out_valid !== 1'b1 || out_sof !== logic'(j == 0) || out_re !== 16'(exp_seq[j])) begin
                errors++;
                $display("[TB] FAIL bin_order[%0d]: got v=%0b sof=%0b re=%0d, expected v=1 sof=%0b re=%0d",
                         j, out_valid, out_sof, out_re, j == 0, exp_seq[j]);
            end
        end
    endtask

    task automatic test_continuous();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < N; j++) begin
                drive_cycle(1'b1, j == 0, 16'(f * 8 + j), 16'(1000 + f * 8 + j));
                if (f >= 1) begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL continuous_valid f=%0d j=%0d: got %0b, expected 1", f, j, out_valid);
                    end
                end
            end
        end
        checks++;
`ifdef FFT_REORDER_FRAMECNT_EN
        if (out_frame_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL frame_cnt: got %0d, expected 2", out_frame_cnt);
        end
`else
        if (out_frame_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL frame_cnt: got %0d, expected 0", out_frame_cnt);
        end
`endif
    endtask

    task automatic test_gaps();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < N; j++) begin
                drive_cycle(1'b1, j == 0, 16'(300 + f * 8 + j), 16'(400 + f * 8 + j));
                if (f == 1) begin
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL gap_on j=%0d: got out_valid=%0b, expected 1", j, out_valid);
                    end
                end
                drive_cycle(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
                if (f == 1) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL gap_off j=%0d: got out_valid=%0b, expected 0", j, out_valid);
                    end
                end
            end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        for (int j = 0; j < N; j++) drive_cycle(1'b1, j == 0, 16'(400 + j), 16'(j));
        for (int j = 0; j < 3; j++) drive_cycle(1'b1, j == 0, 16'(450 + j), 16'(j));
        for (int j = 0; j < N; j++) begin
            drive_cycle(1'b1, j == 0, 16'(500 + j), 16'(600 + j));
            checks++;
            if (out_valid !== 1'b0 || out_err !== 1'b1) begin
                errors++;
                $display("[TB] FAIL misalign_stall j=%0d: got v=%0b err=%0b, expected v=0 err=1", j, out_valid, out_err);
            end
        end
        for (int j = 0; j < N; j++) drive_cycle(1'b1, j == 0, 16'(700 + j), 16'(800 + j));
        checks++;
        if (out_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_sticky: got err=%0b, expected 1", out_err);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        for (int j = 0; j < N + 4; j++) drive_cycle(1'b1, (j % N) == 0, 16'(900 + j), 16'(j));
        rst = 1'b1;
        drive_cycle(1'b1, 1'b0, 16'h7777, 16'h7777);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_re !== 16'h0 || out_im !== 16'h0 ||
            out_err !== 1'b0 || out_frame_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got v=%0b sof=%0b re=%h im=%h err=%0b fcnt=%0d, expected all zero",
                     out_valid, out_sof, out_re, out_im, out_err, out_frame_cnt);
        end
        for (int j = 0; j < 3; j++) drive_cycle(1'b1, 1'b0, 16'(950 + j), 16'(j));
        for (int j = 0; j < N; j++) begin
            drive_cycle(1'b1, j == 0, 16'(960 + j), 16'(970 + j));
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL refill_silent j=%0d: got out_valid=%0b, expected 0", j, out_valid);
            end
        end
        drive_cycle(1'b1, 1'b1, 16'(980), 16'(990));
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_re !== 16'd960) begin
            errors++;
            $display("[TB] FAIL refill_first_bin: got v=%0b sof=%0b re=%0d, expected v=1 sof=1 re=960",
                     out_valid, out_sof, out_re);
        end
        for (int j = 1; j < N; j++) drive_cycle(1'b1, 1'b0, 16'(980 + j), 16'(990 + j));
    endtask

    task automatic test_extremes();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < N; j++) begin
                if (j % 2 == 0) drive_cycle(1'b1, j == 0, 16'h8000, 16'h7FFF);
                else            drive_cycle(1'b1, j == 0, 16'h7FFF, 16'h8000);
                if (f == 1 && (j == 0 || j == 4)) begin
                    checks++;
                    if (j == 0 && (out_re !== 16'h8000 || out_im !== 16'h7FFF)) begin
                        errors++;
                        $display("[TB] FAIL extreme_bin0: got re=%h im=%h, expected re=8000 im=7fff", out_re, out_im);
                    end
                    if (j == 4 && (out_re !== 16'h7FFF || out_im !== 16'h8000)) begin
                        errors++;
                        $display("[TB] FAIL extreme_bin4: got re=%h im=%h, expected re=7fff im=8000", out_re, out_im);
                    end
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_state  = 0;
        m_cnt    = 0;
        m_last   = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = 16'h0;
        in_im    = 16'h0;
        mon_en   = 1'b1;

        test_reset();
        test_two_frames();
        test_continuous();
        test_gaps();
        test_misalign();
        test_reset_mid_stream();
        test_extremes();

        drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
